// File: rtl/icache_direct_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Frame layout and FSM state encoding live here so the datapath side can reuse them.
package icache_direct_pkg;

    localparam int WORD_W = 32;
    localparam int SETS   = 16;
    localparam int IIDX_W = $clog2(SETS);
    localparam int ITAG_W = WORD_W - IIDX_W - 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        MISS
    } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, read-only, one-word-per-block instruction cache.
// Hits return in the request cycle; misses stall in MISS until the memory port delivers.
module icache_direct
    import icache_direct_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);

    icache_state_t state, next_state;
    icache_frame_t frames [SETS];
    word_t         miss_addr;

    logic [IIDX_W-1:0] req_idx;
    logic [ITAG_W-1:0] req_tag;
    logic [IIDX_W-1:0] miss_idx;
    logic [ITAG_W-1:0] miss_tag;
    icache_frame_t     req_frame;
    logic              hit;
    logic              fill;

    assign req_idx   = imemaddr[IIDX_W+1:2];
    assign req_tag   = imemaddr[WORD_W-1:IIDX_W+2];
    assign miss_idx  = miss_addr[IIDX_W+1:2];
    assign miss_tag  = miss_addr[WORD_W-1:IIDX_W+2];
    assign req_frame = frames[req_idx];

    // Byte offsets never matter for word-aligned fetches.
    logic unused_offset;
    assign unused_offset = ^{imemaddr[1:0], miss_addr[1:0]};

    assign hit  = (state == IDLE) && imemREN && req_frame.valid && (req_frame.tag == req_tag);
    assign fill = (state == MISS) && !iwait;

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
            for (int i = 0; i < SETS; i++) begin
                frames[i] <= '0;
            end
        end else begin
            state <= next_state;
            if ((state == IDLE) && imemREN && !hit) begin
                miss_addr <= imemaddr;
            end
            if (fill) begin
                frames[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
            end
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = req_frame.data;
        iREN       = 1'b0;
        iaddr      = imemaddr;
        unique case (state)
            IDLE: begin
                ihit = hit;
                if (imemREN && !hit) begin
                    next_state = MISS;
                end
            end
            MISS: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                // The fill cycle itself never reports a hit; the frame is readable next cycle.
                if (!iwait) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct.
// Drives inputs just after each rising edge and checks outputs before the next one.
module tb_icache_direct;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int testCount = 0;
    int failCount = 0;

    icache_direct dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ren, input logic [31:0] addr,
                                 input logic wt, input logic [31:0] load);
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = load;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    // Cold or conflict miss on addr, memory busy for waitCycles, then data arrives.
    task automatic doMiss(input logic [31:0] addr, input logic [31:0] data, input int waitCycles);
        applyStimulus(1'b1, addr, 1'b1, 32'h0);
        checkOutput("miss_detect_ihit", {31'b0, ihit}, 32'd0);
        checkOutput("miss_detect_iren", {31'b0, iREN}, 32'd0);
        nextCycle();
        for (int i = 0; i < waitCycles; i++) begin
            checkOutput("miss_wait_iren", {31'b0, iREN}, 32'd1);
            checkOutput("miss_wait_iaddr", iaddr, addr);
            checkOutput("miss_wait_ihit", {31'b0, ihit}, 32'd0);
            nextCycle();
        end
        applyStimulus(1'b1, addr, 1'b0, data);
        checkOutput("fill_iaddr", iaddr, addr);
        checkOutput("fill_ihit", {31'b0, ihit}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, addr, 1'b1, 32'h0);
        checkOutput("after_fill_ihit", {31'b0, ihit}, 32'd1);
        checkOutput("after_fill_data", imemload, data);
        checkOutput("after_fill_iren", {31'b0, iREN}, 32'd0);
    endtask

    initial begin
        nRST = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);

        // Reset held for two edges.
        nextCycle();
        nextCycle();
        checkOutput("reset_imemload", imemload, 32'h0);
        checkOutput("reset_iren", {31'b0, iREN}, 32'd0);
        checkOutput("reset_ihit", {31'b0, ihit}, 32'd0);

        // Cold miss on 0x40 with three busy cycles.
        nRST = 1'b0;
        doMiss(32'h0000_0040, 32'h2001_0005, 3);

        // Repeat fetch hits with no memory traffic.
        nextCycle();
        checkOutput("repeat_ihit", {31'b0, ihit}, 32'd1);
        checkOutput("repeat_iren", {31'b0, iREN}, 32'd0);
        checkOutput("repeat_data", imemload, 32'h2001_0005);

        // Conflict: 0x440 shares index 0 and evicts 0x40.
        nextCycle();
        doMiss(32'h0000_0440, 32'h8C22_0000, 1);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        checkOutput("conflict_ihit", {31'b0, ihit}, 32'd0);
        nextCycle();
        checkOutput("conflict_iaddr", iaddr, 32'h0000_0040);
        checkOutput("conflict_iren", {31'b0, iREN}, 32'd1);

        // Redirect mid-miss: fill for 0x40 still lands, then 0x80 misses in turn.
        applyStimulus(1'b1, 32'h0000_0080, 1'b1, 32'h0);
        checkOutput("redirect_hold_iaddr", iaddr, 32'h0000_0040);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 32'h1111_1111);
        checkOutput("redirect_fill_iaddr", iaddr, 32'h0000_0040);
        checkOutput("redirect_fill_ihit", {31'b0, ihit}, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0080, 1'b1, 32'h0);
        checkOutput("redirect_new_ihit", {31'b0, ihit}, 32'd0);
        checkOutput("redirect_frame_data", imemload, 32'h1111_1111);
        checkOutput("redirect_new_iren", {31'b0, iREN}, 32'd0);
        nextCycle();
        checkOutput("redirect_miss_iaddr", iaddr, 32'h0000_0080);
        checkOutput("redirect_miss_iren", {31'b0, iREN}, 32'd1);
        applyStimulus(1'b1, 32'h0000_0080, 1'b0, 32'h2222_2222);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0080, 1'b1, 32'h0);
        checkOutput("redirect_0x80_ihit", {31'b0, ihit}, 32'd1);
        checkOutput("redirect_0x80_data", imemload, 32'h2222_2222);

        // Without a request there is no hit and no miss.
        applyStimulus(1'b0, 32'h0000_0080, 1'b1, 32'h0);
        checkOutput("noreq_ihit", {31'b0, ihit}, 32'd0);
        nextCycle();
        checkOutput("noreq_iren", {31'b0, iREN}, 32'd0);

        // 0x80 now owns index 0, so 0x40 misses.
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        checkOutput("evicted_ihit", {31'b0, ihit}, 32'd0);
        nextCycle();
        checkOutput("evicted_iren", {31'b0, iREN}, 32'd1);

        // Reset mid-miss coinciding with a fill: reset wins.
        nRST = 1'b1;
        applyStimulus(1'b1, 32'h0000_0040, 1'b0, 32'hDEAD_BEEF);
        nextCycle();
        nRST = 1'b0;
        applyStimulus(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        checkOutput("midmiss_reset_iren", {31'b0, iREN}, 32'd0);
        checkOutput("midmiss_reset_ihit", {31'b0, ihit}, 32'd0);
        checkOutput("midmiss_reset_data", imemload, 32'h0);
        nextCycle();
        checkOutput("post_reset_miss_iren", {31'b0, iREN}, 32'd1);
        checkOutput("post_reset_miss_iaddr", iaddr, 32'h0000_0040);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
